pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter EX_W, default 10, EX-stage control field width.
REQ-002 SHALL have parameter MEM_W, default 13, MEM-stage control field width.
REQ-003 SHALL have parameter WB_W, default 10, WB-stage control field width.
REQ-004 SHALL have parameter DATA_W, default 32, datapath payload width (PC, operands).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port flush  input  1  synchronous kill of all held entries (bubble insert).
REQ-008 SHALL have port in_valid  input  1  upstream entry present.
REQ-009 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-010 SHALL have ports in_ex/in_mem/in_wb  input  EX_W/MEM_W/WB_W  control groups.
REQ-011 SHALL have port in_data  input  DATA_W  payload.
REQ-012 SHALL have port out_valid  output  1  head entry present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts.
REQ-014 SHALL have ports out_ex/out_mem/out_wb/out_data  output  matching widths  head entry fields.
REQ-015 SHALL have port stall_cnt  output  16  cycles with out_valid=1 and out_ready=0.

Function
REQ-016 SHALL accept an entry only on in_valid && in_ready; SHALL retire the head only on out_valid && out_ready.
REQ-017 SHALL present an accepted entry on outputs exactly 1 cycle after acceptance when the stage was empty or draining.
REQ-018 SHALL preserve entry order; no entry duplicated or dropped except by flush.
REQ-019 SHALL drive out_ex, out_mem, out_wb and out_data all-zero whenever out_valid=0 (bubble is decode-safe without checking valid).
REQ-020 SHALL hold head fields stable while out_valid=1 and out_ready=0.
REQ-021 SHALL on flush=1 make all entries invalid at the next edge, zero all held fields, and discard any same-cycle input (flush beats accept and retire).
REQ-022 SHALL keep in_ready meaningful during flush; an entry offered in a flush cycle is not stored.
REQ-023 SHALL increment stall_cnt by 1 per cycle with out_valid=1 and out_ready=0, saturating at 16'hFFFF; flush does not clear it.
REQ-024 SHALL tolerate in_valid dropping or in_* changing while in_ready=0 without corrupting held entries.

Reset
REQ-025 SHALL on rst_n=0 asynchronously clear all entries: out_valid=0, out_ex/out_mem/out_wb/out_data=0, stall_cnt=0.
REQ-026 SHALL drive in_ready=1 from the first edge after rst_n deasserts.
REQ-027 SHALL abort any in-flight entry on reset mid-operation; nothing survives reset.

Configuration
REQ-028 SHALL use macro PIPE_STAGE_REG_SKID_EN to select buffering.
REQ-029 SHALL with PIPE_STAGE_REG_SKID_EN undefined hold one entry; in_ready = !out_valid || out_ready (combinational from out_ready).
REQ-030 SHALL with PIPE_STAGE_REG_SKID_EN defined hold two entries (main + skid); in_ready is a register output equal to "skid empty", with no combinational path from out_ready.
REQ-031 SHALL with skid: entry accepted while main is valid and stalled goes to skid; when main retires, skid moves to main next edge; in_ready drops the edge after skid fills and rises the edge after it empties.
REQ-032 SHALL give identical ordering, latency-when-unstalled, flush and reset behaviour in both configurations.

Verification
REQ-033 SHALL cover reset: drive rst_n=0 mid-stream with out_valid=1 -> out_valid=0, all fields 0, stall_cnt=0 immediately (no clock).
REQ-034 SHALL cover streaming: in_valid=1 every cycle, out_ready=1, in_data=1,2,3,... -> out_data 1,2,3,... one cycle later, in_ready constant 1.
REQ-035 SHALL cover backpressure: out_ready=0 for 3 cycles with in_valid=1, in_data=A,B,C -> no-skid: out holds A, in_ready=0, stall_cnt=3; skid: A held, B in skid, in_ready=0 after 2nd accept; release -> A,B then C in order.
REQ-036 SHALL cover flush: flush=1 while holding 2 entries and in_valid=1, in_data=D -> next cycle out_valid=0, all outputs 0, D never appears.
REQ-037 SHALL cover saturation: out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and stays there.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake bus for pipe_stage_reg: upstream in_* channel and downstream out_* channel.
// master = producer/consumer side (testbench or neighbouring stages), slave = the stage register.
interface pipe_stage_reg_if #(
  parameter int EX_W   = 10,
  parameter int MEM_W  = 13,
  parameter int WB_W   = 10,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [EX_W-1:0]   in_ex;
  logic [MEM_W-1:0]  in_mem;
  logic [WB_W-1:0]   in_wb;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [EX_W-1:0]   out_ex;
  logic [MEM_W-1:0]  out_mem;
  logic [WB_W-1:0]   out_wb;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ex, in_mem, in_wb, in_data, out_ready,
    input  in_ready, out_valid, out_ex, out_mem, out_wb, out_data
  );

  modport slave (
    input  in_valid, in_ex, in_mem, in_wb, in_data, out_ready,
    output in_ready, out_valid, out_ex, out_mem, out_wb, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and stall counter.
// Define PIPE_STAGE_REG_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
  parameter int EX_W   = 10,
  parameter int MEM_W  = 13,
  parameter int WB_W   = 10,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  pipe_stage_reg_if.slave      bus,
  output logic [15:0]          stall_cnt
);

  typedef struct packed {
    logic [EX_W-1:0]   ex;
    logic [MEM_W-1:0]  mem;
    logic [WB_W-1:0]   wb;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t in_e;
  entry_t main_q;
  logic   main_vq;
  logic   accept;
  logic   retire;

  assign in_e   = {bus.in_ex, bus.in_mem, bus.in_wb, bus.in_data};
  assign retire = main_vq && bus.out_ready;

  // Held fields are zeroed on every path that invalidates the entry, so the
  // outputs need no valid gating to read as a decode-safe bubble.
  assign {bus.out_ex, bus.out_mem, bus.out_wb, bus.out_data} = main_q;
  assign bus.out_valid = main_vq;

`ifdef PIPE_STAGE_REG_SKID_EN
  entry_t skid_q;
  logic   skid_vq;
  logic   in_ready_q;
  logic   main_free;

  assign bus.in_ready = in_ready_q;
  assign accept       = bus.in_valid && in_ready_q;
  assign main_free    = !main_vq || retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vq    <= 1'b0;
      main_q     <= '0;
      skid_vq    <= 1'b0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      main_vq    <= 1'b0;
      main_q     <= '0;
      skid_vq    <= 1'b0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else if (main_free) begin
      // Skid is only ever full while in_ready_q=0, so it cannot race an accept.
      if (skid_vq) begin
        main_q     <= skid_q;
        main_vq    <= 1'b1;
        skid_q     <= '0;
        skid_vq    <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (accept) begin
        main_q  <= in_e;
        main_vq <= 1'b1;
      end else begin
        main_q  <= '0;
        main_vq <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= in_e;
      skid_vq    <= 1'b1;
      in_ready_q <= 1'b0;
    end
  end
`else
  // NOTE: in_ready is combinational from out_ready here; a chain of these
  // stages forms one long ready path, which the skid build breaks.
  assign bus.in_ready = !main_vq || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vq <= 1'b0;
      main_q  <= '0;
    end else if (flush) begin
      main_vq <= 1'b0;
      main_q  <= '0;
    end else if (accept) begin
      main_q  <= in_e;
      main_vq <= 1'b1;
    end else if (retire) begin
      main_q  <= '0;
      main_vq <= 1'b0;
    end
  end
`endif

  // Stall counter saturates and deliberately survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (main_vq && !bus.out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table plus handshake, flush,
// reset and saturation sequences. Honours PIPE_STAGE_REG_SKID_EN when defined.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] stall_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  pipe_stage_reg_if bus_if ();

  pipe_stage_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus_if),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;

  function automatic logic [9:0]  f_ex (input logic [31:0] d); return d[9:0] ^ 10'h155; endfunction
  function automatic logic [12:0] f_mem(input logic [31:0] d); return d[20:8];          endfunction
  function automatic logic [9:0]  f_wb (input logic [31:0] d); return d[31:22] ^ 10'h2AA; endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic v, input logic [31:0] d);
    check({name, "_valid"}, 64'(bus_if.out_valid), 64'(v));
    check({name, "_data"},  64'(bus_if.out_data),  64'(v ? d : 32'd0));
    check({name, "_ex"},    64'(bus_if.out_ex),    64'(v ? f_ex(d)  : 10'd0));
    check({name, "_mem"},   64'(bus_if.out_mem),   64'(v ? f_mem(d) : 13'd0));
    check({name, "_wb"},    64'(bus_if.out_wb),    64'(v ? f_wb(d)  : 10'd0));
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    flush            = fl;
    bus_if.in_valid  = iv;
    bus_if.in_data   = d;
    bus_if.in_ex     = f_ex(d);
    bus_if.in_mem    = f_mem(d);
    bus_if.in_wb     = f_wb(d);
    bus_if.out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] A = 32'hA0A0_0001, B = 32'hB0B0_0002, C = 32'hC0C0_0003;
  localparam logic [31:0] D = 32'hD0D0_0004, E = 32'hE0E0_0005, F = 32'hF0F0_0006;
  localparam logic [31:0] G = 32'h1234_5678, H = 32'h8765_4321;

  vec_t        vecs[11];
  logic [31:0] src[$];
  logic [31:0] got[$];
  logic        fire_in;

  initial begin
    //            fl    iv    d      ordy  rdy   v     d
    vecs[0]  = '{1'b0, 1'b1, 32'd1, 1'b1, 1'b1, 1'b1, 32'd1};
    vecs[1]  = '{1'b0, 1'b1, 32'd2, 1'b1, 1'b1, 1'b1, 32'd2};
    vecs[2]  = '{1'b0, 1'b1, 32'd3, 1'b1, 1'b1, 1'b1, 32'd3};
    vecs[3]  = '{1'b0, 1'b1, 32'd4, 1'b1, 1'b1, 1'b1, 32'd4};
    vecs[4]  = '{1'b0, 1'b0, 32'd9, 1'b1, 1'b1, 1'b0, 32'd0};
    vecs[5]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0};
    vecs[6]  = '{1'b0, 1'b1, 32'd5, 1'b0, 1'b1, 1'b1, 32'd5};
    vecs[7]  = '{1'b0, 1'b0, 32'd7, 1'b1, 1'b1, 1'b0, 32'd0};
    vecs[8]  = '{1'b1, 1'b1, 32'd8, 1'b1, 1'b1, 1'b0, 32'd0};
    vecs[9]  = '{1'b0, 1'b1, 32'd10, 1'b1, 1'b1, 1'b1, 32'd10};
    vecs[10] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0};

    // Reset state
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    #2;
    check_out("reset", 1'b0, 32'd0);
    check("reset_stall", 64'(stall_cnt), 64'd0);
    #10 rst_n = 1'b1;
    step();
    check("post_reset_in_ready", 64'(bus_if.in_ready), 64'd1);

    // Streaming, bubbles, flush-over-accept
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(bus_if.in_ready), 64'(vecs[i].exp_rdy));
      step();
      check_out($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_d);
    end
    check("table_stall", 64'(stall_cnt), 64'd0);

    // Backpressure: stall four cycles with a well-behaved source, then release
    src = '{A, B, C};
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, src.size() != 0, (src.size() != 0) ? src[0] : 32'd0, c >= 4);
      #1;
      if (c == 1) check("bp_in_ready_2nd", 64'(bus_if.in_ready), 64'(SKID));
      fire_in = bus_if.in_valid && bus_if.in_ready;
      if (bus_if.out_valid && bus_if.out_ready) got.push_back(bus_if.out_data);
      step();
      if (fire_in) void'(src.pop_front());
      if (c == 3) begin
        check_out("bp_hold", 1'b1, A);
        check("bp_stall", 64'(stall_cnt), 64'd3);
        check("bp_in_ready_full", 64'(bus_if.in_ready), 64'd0);
      end
    end
    check("bp_count", 64'(got.size()), 64'd3);
    check("bp_order0", 64'((got.size() > 0) ? got[0] : 32'hx), 64'(A));
    check("bp_order1", 64'((got.size() > 1) ? got[1] : 32'hx), 64'(B));
    check("bp_order2", 64'((got.size() > 2) ? got[2] : 32'hx), 64'(C));

    // Flush while holding entries, with a same-cycle offer that must vanish
    src = '{E, F};
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, src.size() != 0, (src.size() != 0) ? src[0] : 32'd0, 1'b0);
      #1;
      fire_in = bus_if.in_valid && bus_if.in_ready;
      step();
      if (fire_in) void'(src.pop_front());
    end
    check_out("pre_flush", 1'b1, E);
    drive(1'b1, 1'b1, D, 1'b1);
    step();
    check_out("flush", 1'b0, 32'd0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      step();
      check_out($sformatf("post_flush%0d", c), 1'b0, 32'd0);
    end
    check("flush_keeps_stall", 64'(stall_cnt), 64'd4);
    check("post_flush_in_ready", 64'(bus_if.in_ready), 64'd1);

    // Asynchronous reset mid-stream, no clock edge needed
    drive(1'b0, 1'b1, G, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    step();
    check_out("pre_areset", 1'b1, G);
    #2 rst_n = 1'b0;
    #1;
    check_out("areset", 1'b0, 32'd0);
    check("areset_stall", 64'(stall_cnt), 64'd0);
    #2 rst_n = 1'b1;
    step();
    check("areset_in_ready", 64'(bus_if.in_ready), 64'd1);
    check_out("areset_after", 1'b0, 32'd0);

    // Saturation: 70000 stalled cycles
    drive(1'b0, 1'b1, H, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    check_out("sat_load", 1'b1, H);
    repeat (65534) step();
    check("sat_fffe", 64'(stall_cnt), 64'hFFFE);
    step();
    check("sat_ffff", 64'(stall_cnt), 64'hFFFF);
    repeat (4465) step();
    check("sat_hold", 64'(stall_cnt), 64'hFFFF);
    check_out("sat_entry", 1'b1, H);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
